// File: rtl/sr_latch_driver.sv
// Sequencer that turns masked write requests into non-overlapping S/R pulses for an SR latch bank.
// Define SR_DRIVER_CHECK_EN to enable Q-feedback checking with retries and the err pulse.
module sr_latch_driver #(
    parameter int WIDTH         = 4,
    parameter int PULSE_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] req_value,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

    localparam int MAX_CYC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mask_q, value_q;
    logic [WIDTH-1:0]   eff_mask, eff_value;
    logic [WIDTH-1:0]   s_d, r_d;
    logic               done_d, err_d, ready_d;
    logic               accept;
    logic               match;
    logic               retry_left;

    assign accept = req_valid && req_ready;

`ifdef SR_DRIVER_CHECK_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] retry;

    assign match      = ((q_fb ^ value_q) & mask_q) == '0;
    assign retry_left = retry != RETRY_W'(MAX_RETRY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry <= '0;
        end else if (accept) begin
            retry <= '0;
        end else if (state == CHECK && !match && retry_left) begin
            retry <= retry + 1'b1;
        end
    end
`else
    // Feedback is ignored in this build; these signals only keep the port and parameter referenced.
    logic unused_cfg;

    assign match      = 1'b1;
    assign retry_left = 1'b0;
    assign unused_cfg = (^q_fb) ^ (MAX_RETRY < 0);
`endif

    // State register and phase counter; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
            if (state_n != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // NOTE: request data registers carry no reset; they are only read after an accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            mask_q  <= req_mask;
            value_q <= req_value;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_n unassigned (no latch).
        state_n = state;
        case (state)
            IDLE: begin
                if (accept && req_mask != '0) begin
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_n = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (match || !retry_left) begin
                    state_n = IDLE;
                end else begin
                    state_n = DRIVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state and registered, so S/R never glitch.
    always_comb begin
        eff_mask  = (state == IDLE) ? req_mask  : mask_q;
        eff_value = (state == IDLE) ? req_value : value_q;
        s_d       = '0;
        r_d       = '0;
        if (state_n == DRIVE) begin
            s_d = eff_mask & eff_value;
            r_d = eff_mask & ~eff_value;
        end
        done_d  = (state == IDLE && accept && req_mask == '0) || (state == CHECK && match);
        err_d   = state == CHECK && !match && !retry_left;
        ready_d = state_n == IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S         <= '0;
            R         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            S         <= s_d;
            R         <= r_d;
            done      <= done_d;
            err       <= err_d;
            req_ready <= ready_d;
        end
    end

endmodule
